// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl -- frequency-sweep sequencer for a DDS waveform generator.
//
// Steps a phase increment from f_start toward f_stop in f_step increments,
// holding each value for max(dwell,1) clock cycles, then pulses done.
//
// Ports
//   clk        in   single clock, all state on the rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   sweep request (accepted only while idle)
//   abort      in   cancel sweep; wins over start
//   f_start    in   first phase increment            [PW]
//   f_stop     in   final phase increment            [PW]
//   f_step     in   increment added per step         [PW]
//   dwell      in   cycles each frequency is held    [DW]
//   phase_inc  out  registered phase increment       [PW]
//   dds_en     out  registered DDS enable
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at sweep completion
//   bidir      in   (only with DDS_SWEEP_BIDIR_EN) up/down ping-pong sweep
//
// Build option: define DDS_SWEEP_BIDIR_EN to add the bidir port and the
// DOWN state. Without it, sweeps are up-only.
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int PW = 32,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [PW-1:0] f_start,
    input  logic [PW-1:0] f_stop,
    input  logic [PW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    output logic [PW-1:0] phase_inc,
    output logic          dds_en,
    output logic          busy,
    output logic          done
`ifdef DDS_SWEEP_BIDIR_EN
    ,
    input  logic          bidir
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DWELL = 3'd1;  // holding an up-going tone, not its last cycle
    localparam logic [2:0] STEP  = 3'd2;  // last cycle of an up-going tone; next tone loads at its end
    localparam logic [2:0] FINAL = 3'd3;  // holding f_stop
    localparam logic [2:0] DONE  = 3'd4;  // done pulse cycle
`ifdef DDS_SWEEP_BIDIR_EN
    localparam logic [2:0] DOWN  = 3'd5;  // holding a down-going tone
`endif

    localparam logic [DW-1:0] CNT_ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] f_stop_q, f_stop_d;
    logic [PW-1:0] f_step_q, f_step_d;
    logic [DW-1:0] dwell_q, dwell_d;
`ifdef DDS_SWEEP_BIDIR_EN
    logic [PW-1:0] f_start_q, f_start_d;
    logic          bidir_q, bidir_d;
    logic [PW:0]   diff;
    logic          down_floor;
`endif

    logic [DW-1:0] dwell_eff;
    logic [DW-1:0] cnt_inc;
    logic [PW:0]   sum;
    logic [2:0]    up_state;

    // Counter holds the 1-based index of the current cycle within a tone.
    assign dwell_eff = (dwell_q == '0) ? CNT_ONE : dwell_q;
    assign cnt_inc   = cnt_q + CNT_ONE;
    // One extra bit so a step past the top of the range saturates at f_stop
    // instead of wrapping to a small increment.
    assign sum       = {1'b0, phase_q} + {1'b0, f_step_q};
    // A one-cycle dwell has no non-final cycle, so a fresh tone starts in STEP.
    assign up_state  = (dwell_q <= CNT_ONE) ? STEP : DWELL;
`ifdef DDS_SWEEP_BIDIR_EN
    assign diff       = {1'b0, phase_q} - {1'b0, f_step_q};
    assign down_floor = diff[PW] || (diff[PW-1:0] <= f_start_q);
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        en_d     = en_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        f_stop_d = f_stop_q;
        f_step_d = f_step_q;
        dwell_d  = dwell_q;
`ifdef DDS_SWEEP_BIDIR_EN
        f_start_d = f_start_q;
        bidir_d   = bidir_q;
`endif
        if (abort) begin
            state_d = IDLE;
            phase_d = '0;
            en_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        f_stop_d = f_stop;
                        f_step_d = f_step;
                        dwell_d  = dwell;
`ifdef DDS_SWEEP_BIDIR_EN
                        f_start_d = f_start;
                        bidir_d   = bidir;
`endif
                        phase_d  = f_start;
                        en_d     = 1'b1;
                        cnt_d    = CNT_ONE;
                        state_d  = (dwell <= CNT_ONE) ? STEP : DWELL;
                    end
                end
                DWELL: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= dwell_eff) begin
                        state_d = STEP;
                    end
                end
                STEP: begin
                    cnt_d = CNT_ONE;
                    if (f_step_q == '0) begin
                        // Single-tone mode: re-dwell on the same value forever.
                        state_d = up_state;
                    end else if (phase_q >= f_stop_q) begin
                        // Only reachable when f_start >= f_stop: one dwell, then done.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (sum >= {1'b0, f_stop_q}) begin
                        phase_d = f_stop_q;
                        state_d = FINAL;
                    end else begin
                        phase_d = sum[PW-1:0];
                        state_d = up_state;
                    end
                end
                FINAL: begin
                    if (cnt_q >= dwell_eff) begin
`ifdef DDS_SWEEP_BIDIR_EN
                        if (bidir_q) begin
                            cnt_d = CNT_ONE;
                            if (down_floor) begin
                                phase_d = f_start_q;
                                state_d = up_state;
                            end else begin
                                phase_d = diff[PW-1:0];
                                state_d = DOWN;
                            end
                        end else
`endif
                        begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                DONE: begin
                    // phase_inc and dds_en keep the final tone running while idle.
                    state_d = IDLE;
                    cnt_d   = '0;
                end
`ifdef DDS_SWEEP_BIDIR_EN
                DOWN: begin
                    if (cnt_q >= dwell_eff) begin
                        cnt_d = CNT_ONE;
                        if (down_floor) begin
                            phase_d = f_start_q;
                            state_d = up_state;
                        end else begin
                            phase_d = diff[PW-1:0];
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            f_stop_q <= '0;
            f_step_q <= '0;
            dwell_q  <= '0;
`ifdef DDS_SWEEP_BIDIR_EN
            f_start_q <= '0;
            bidir_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            f_stop_q <= f_stop_d;
            f_step_q <= f_step_d;
            dwell_q  <= dwell_d;
`ifdef DDS_SWEEP_BIDIR_EN
            f_start_q <= f_start_d;
            bidir_q   <= bidir_d;
`endif
        end
    end

    assign phase_inc = phase_q;
    assign dds_en    = en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl -- directed, self-checking bench for dds_sweep_ctrl.
// Expected per-cycle outputs are queued as each step is set up and compared
// one entry per clock as the DUT runs.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] dwell;
    logic [31:0] phase_inc;
    logic        dds_en;
    logic        busy;
    logic        done;
`ifdef DDS_SWEEP_BIDIR_EN
    logic        bidir;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] ph;
        logic        en;
        logic        bsy;
        logic        dn;
    } exp_t;

    exp_t sb[$];

    dds_sweep_ctrl #(.PW(32), .DW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .phase_inc (phase_inc),
        .dds_en    (dds_en),
        .busy      (busy),
        .done      (done)
`ifdef DDS_SWEEP_BIDIR_EN
        ,
        .bidir     (bidir)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] ph, input logic en, input logic bsy,
                        input logic dn, input int n);
        exp_t e;
        e.ph = ph; e.en = en; e.bsy = bsy; e.dn = dn;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic set_params(input logic [31:0] fs, input logic [31:0] fe,
                              input logic [31:0] st, input logic [15:0] dw);
        f_start = fs; f_stop = fe; f_step = st; dwell = dw;
    endtask

    // One clock per queued entry; start/abort are single-edge strobes.
    task automatic run_sb(input string tag);
        exp_t e;
        int   n = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            e = sb.pop_front();
            check({tag, "/phase_inc"}, phase_inc, e.ph);
            check({tag, "/dds_en"}, {31'd0, dds_en}, {31'd0, e.en});
            check({tag, "/busy"}, {31'd0, busy}, {31'd0, e.bsy});
            check({tag, "/done"}, {31'd0, done}, {31'd0, e.dn});
            n++;
        end
        $display("step %-12s %0d cycles compared", tag, n);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/phase_inc"}, phase_inc, 32'h0);
        check({tag, "/dds_en"}, {31'd0, dds_en}, 32'h0);
        check({tag, "/busy"}, {31'd0, busy}, 32'h0);
        check({tag, "/done"}, {31'd0, done}, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_params(32'h0, 32'h0, 32'h0, 16'd0);
`ifdef DDS_SWEEP_BIDIR_EN
        bidir = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        $display("step %-12s outputs compared", "reset");
        reset = 1'b1;

        // Basic up sweep, then idle holding f_stop.
        set_params(32'h100, 32'h400, 32'h102, 16'd3);
        start = 1'b1;
        push(32'h100, 1, 1, 0, 3);
        push(32'h202, 1, 1, 0, 3);
        push(32'h304, 1, 1, 0, 3);
        push(32'h400, 1, 1, 0, 3);
        push(32'h400, 1, 1, 1, 1);
        push(32'h400, 1, 0, 0, 2);
        run_sb("sweep_up");

        // Top of range: the final step must saturate at f_stop, not wrap.
        set_params(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd1);
        start = 1'b1;
        push(32'hFFFF_FF00, 1, 1, 0, 1);
        push(32'hFFFF_FF80, 1, 1, 0, 1);
        push(32'hFFFF_FFFF, 1, 1, 0, 1);
        push(32'hFFFF_FFFF, 1, 1, 1, 1);
        push(32'hFFFF_FFFF, 1, 0, 0, 2);
        run_sb("no_wrap");

        // f_start >= f_stop: one dwell at f_start, then done.
        set_params(32'h500, 32'h400, 32'h10, 16'd2);
        start = 1'b1;
        push(32'h500, 1, 1, 0, 2);
        push(32'h500, 1, 1, 1, 1);
        push(32'h500, 1, 0, 0, 1);
        run_sb("start_ge");

        // Abort from idle clears the held tone.
        abort = 1'b1;
        push(32'h0, 0, 0, 0, 2);
        run_sb("abort_idle");

        // Start while busy is ignored; abort with start wins.
        set_params(32'h100, 32'h400, 32'h102, 16'd3);
        start = 1'b1;
        push(32'h100, 1, 1, 0, 1);
        run_sb("abort_a");
        start = 1'b1;
        set_params(32'h999, 32'h5, 32'h1, 16'd1);
        push(32'h100, 1, 1, 0, 2);
        push(32'h202, 1, 1, 0, 2);
        run_sb("busy_start");
        abort = 1'b1;
        start = 1'b1;
        push(32'h0, 0, 0, 0, 3);
        run_sb("abort_b");

        // Asynchronous reset mid-sweep.
        set_params(32'h100, 32'h400, 32'h102, 16'd3);
        start = 1'b1;
        push(32'h100, 1, 1, 0, 2);
        run_sb("pre_reset");
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        $display("step %-12s outputs compared", "async_rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push(32'h0, 0, 0, 0, 3);
        run_sb("post_reset");
        start = 1'b1;
        push(32'h100, 1, 1, 0, 3);
        push(32'h202, 1, 1, 0, 1);
        run_sb("restart");
        abort = 1'b1;
        push(32'h0, 0, 0, 0, 1);
        run_sb("abort_c");

        // Single tone: dwell=0, f_step=0.
        set_params(32'h102, 32'h400, 32'h0, 16'd0);
        start = 1'b1;
        push(32'h102, 1, 1, 0, 1000);
        run_sb("single_tone");
        abort = 1'b1;
        push(32'h0, 0, 0, 0, 1);
        run_sb("abort_d");

`ifdef DDS_SWEEP_BIDIR_EN
        // Ping-pong sweep.
        set_params(32'h100, 32'h300, 32'h100, 16'd2);
        bidir = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(32'h100 + ((k == 0) ? 32'h0 : 32'h100), 1, 1, 0, (k == 0) ? 2 : 0);
        end
        push(32'h200, 1, 1, 0, 2);
        push(32'h300, 1, 1, 0, 2);
        push(32'h200, 1, 1, 0, 2);
        push(32'h100, 1, 1, 0, 2);
        push(32'h200, 1, 1, 0, 2);
        push(32'h300, 1, 1, 0, 2);
        push(32'h200, 1, 1, 0, 2);
        push(32'h100, 1, 1, 0, 2);
        run_sb("bidir");
        bidir = 1'b0;
        abort = 1'b1;
        push(32'h0, 0, 0, 0, 1);
        run_sb("abort_e");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PW, default 32, phase-increment width (matches waveform_gen phase_inc).
REQ-002 SHALL have parameter DW, default 16, dwell-counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  sweep request, sampled on clk.
REQ-006 SHALL have port abort  input  1  cancel sweep, sampled on clk.
REQ-007 SHALL have port f_start  input  PW  first phase increment.
REQ-008 SHALL have port f_stop  input  PW  final phase increment.
REQ-009 SHALL have port f_step  input  PW  increment added per step.
REQ-010 SHALL have port dwell  input  DW  cycles each frequency is held.
REQ-011 SHALL have port phase_inc  output  PW  registered, drives waveform_gen phase_inc.
REQ-012 SHALL have port dds_en  output  1  registered, drives waveform_gen en.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at sweep completion.

Function
REQ-015 SHALL implement states IDLE, DWELL, STEP, FINAL, DONE (plus DOWN when configured).
REQ-016 SHALL, on start=1 in IDLE, latch f_start/f_stop/f_step/dwell; next cycle phase_inc=f_start, dds_en=1, state DWELL.
REQ-017 SHALL hold each frequency exactly max(dwell,1) cycles; dwell=0 behaves as 1.
REQ-018 SHALL, at end of dwell in DWELL, compute a PW+1-bit sum phase_inc+f_step; if sum >= f_stop, load f_stop and enter FINAL, else load sum and stay in DWELL; the new value appears on the cycle following the last dwell cycle.
REQ-019 SHALL, after FINAL's dwell expires, enter DONE, assert done for one cycle, then return to IDLE.
REQ-020 SHALL keep phase_inc at f_stop and dds_en=1 in IDLE after completion until next start or abort.
REQ-021 SHALL treat f_step=0 as single-tone: hold f_start indefinitely, never assert done.
REQ-022 SHALL treat f_start >= f_stop as one dwell at f_start followed by DONE.
REQ-023 SHALL ignore start while busy=1; latched parameters SHALL NOT change mid-sweep.
REQ-024 SHALL, on abort=1 in any state, next cycle force IDLE, phase_inc=0, dds_en=0, done=0; abort wins over simultaneous start.

Reset
REQ-025 SHALL, while reset=0, asynchronously force state IDLE, phase_inc=0, dds_en=0, busy=0, done=0, dwell counter=0.
REQ-026 SHALL resume only via a new start after reset deasserts; reset mid-sweep discards the sweep with no done pulse.

Configuration
REQ-027 SHALL, with DDS_SWEEP_BIDIR_EN defined, add input port bidir (1 bit, latched at start); bidir=1 replaces FINAL->DONE with FINAL->DOWN, stepping down by f_step (floored at f_start) then up again, repeating until abort, done never asserted.
REQ-028 SHALL, without DDS_SWEEP_BIDIR_EN, omit the bidir port and the DOWN state; sweeps are up-only.

Verification
REQ-029 SHALL verify f_start=0x100, f_stop=0x400, f_step=0x102, dwell=3 -> phase_inc 0x100,0x202,0x304,0x400 each 3 cycles, done one cycle after last 0x400, busy low after.
REQ-030 SHALL verify f_start=0xFFFFFF00, f_stop=0xFFFFFFFF, f_step=0x80, dwell=1 -> 0xFFFFFF00, 0xFFFFFF80, 0xFFFFFFFF (no wrap), done.
REQ-031 SHALL verify abort asserted in second dwell cycle of 0x202 with start also high -> next cycle phase_inc=0, dds_en=0, busy=0, no done.
REQ-032 SHALL verify reset=0 mid-sweep -> outputs zero immediately without clock edge; start after release restarts at f_start.
REQ-033 SHALL verify dwell=0, f_step=0, f_start=0x102 -> phase_inc=0x102 held 1000 cycles, busy=1, done never asserted.
REQ-034 SHALL verify with DDS_SWEEP_BIDIR_EN, bidir=1, 0x100..0x300 step 0x100 dwell=2 -> 0x100,0x200,0x300,0x200,0x100,0x200,... each 2 cycles, no done.
